// File: rtl/m6502_io_pkg.sv
// Shared definitions for the M6502 memory-mapped serial receive port.
package m6502_io_pkg;

  // Register offsets relative to the port base address
  localparam int unsigned RX_DATA_OFS   = 0;
  localparam int unsigned RX_STATUS_OFS = 1;
  localparam int unsigned RX_COUNT_OFS  = 2;
  localparam int unsigned RX_NUM_REGS   = 3;

  // STATUS register bit positions
  localparam int unsigned ST_AVAIL   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVERRUN = 2;
  localparam int unsigned ST_FRAME   = 3;

  // Receive FSM states
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // STATUS register image as seen on the CPU data bus (bit 0 = avail)
  typedef struct packed {
    logic [3:0] rsvd;
    logic       frame_err;
    logic       overrun;
    logic       full;
    logic       avail;
  } rx_status_t;

endpackage : m6502_io_pkg

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; a pop in the same cycle as
// a push into a full FIFO frees the slot, so the push is accepted.
module uart_rx_fifo #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               drop_c
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_pop_c;
  logic               do_push_c;
  logic [CW-1:0]      count_nxt_c;

  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign drop_c    = push && !do_push_c;
  assign head      = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_nxt_c = count;
    if (do_push_c && !do_pop_c) begin
      count_nxt_c = count + CW'(1);
    end else if (do_pop_c && !do_push_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  // Pointers, occupancy and registered full/empty flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clock) begin
    if (do_push_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule : uart_rx_fifo

// File: rtl/uart_rx_port.sv
// 8N1 serial receiver with a byte FIFO and a three-register CPU bus window
// (RXDATA, STATUS, COUNT) for the M6502 console input path.
module uart_rx_port
  import m6502_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hf018,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        hit,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  // Synchronizer and receive datapath
  logic             rx_meta;
  logic             rxs;
  rx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             expiry_c;
  logic             push_c;
  logic             frame_set_c;

  // FIFO interface
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic             drop_c;

  // Sticky error flags
  logic             overrun;
  logic             frame_err;

  // Bus decode
  logic [15:0]      offset_c;
  logic             wr_data_c;
  logic             wr_status_c;
  logic             pop_c;
  logic [7:0]       rd_data_c;
  rx_status_t       status_c;
  logic             unused_data_bits;

  assign unused_data_bits = ^{data_in[7:4], data_in[1:0]};

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign expiry_c    = (bit_cnt == '0);
  assign push_c      = (state == RX_STOP) && expiry_c && rxs;
  assign frame_set_c = (state == RX_STOP) && expiry_c && !rxs;

  // Receive FSM: start detect, mid-bit sampling, stop check, break hold-off
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            bit_cnt <= HALF_RELOAD;
            state   <= RX_START;
          end
        end
        RX_START: begin
          if (expiry_c) begin
            if (rxs) begin
              state <= RX_IDLE;
            end else begin
              bit_cnt <= FULL_RELOAD;
              bit_idx <= '0;
              state   <= RX_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (expiry_c) begin
            shift_q <= {rxs, shift_q[7:1]};
            bit_cnt <= FULL_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (expiry_c) begin
            state <= rxs ? RX_IDLE : RX_BREAK;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        RX_BREAK: begin
          if (rxs) begin
            state <= RX_IDLE;
          end
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH   (8),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (shift_q),
    .pop       (pop_c),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop_c    (drop_c)
  );

  assign offset_c    = address - BASE_ADDR;
  assign hit         = (offset_c < 16'(RX_NUM_REGS));
  assign wr_data_c   = write_en && (offset_c == 16'(RX_DATA_OFS));
  assign wr_status_c = write_en && (offset_c == 16'(RX_STATUS_OFS));
  assign pop_c       = wr_data_c;

  // Sticky error flags; a new error in the same cycle as a clear wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun   && !(wr_status_c && data_in[ST_OVERRUN])) || drop_c;
      frame_err <= (frame_err && !(wr_status_c && data_in[ST_FRAME]))   || frame_set_c;
    end
  end

  // STATUS image and read-data mux
  always_comb begin
    status_c           = '0;
    status_c.avail     = !fifo_empty;
    status_c.full      = fifo_full;
    status_c.overrun   = overrun;
    status_c.frame_err = frame_err;
    rd_data_c          = 8'h00;
    case (offset_c)
      16'(RX_DATA_OFS):   rd_data_c = fifo_empty ? 8'h00 : fifo_head;
      16'(RX_STATUS_OFS): rd_data_c = status_c;
      16'(RX_COUNT_OFS):  rd_data_c = 8'(fifo_count);
      default:            rd_data_c = 8'h00;
    endcase
  end

  assign data_out = (hit && !write_en) ? rd_data_c : 8'h00;
  assign irq      = !fifo_empty;

endmodule : uart_rx_port

// File: tb/tb_uart_rx_port.sv
// Directed scoreboard bench for uart_rx_port.
module tb_uart_rx_port;

  localparam logic [15:0] BASE = 16'hf018;
  localparam int unsigned CPB  = 16;
  localparam logic [15:0] A_DATA   = BASE;
  localparam logic [15:0] A_STATUS = BASE + 16'd1;
  localparam logic [15:0] A_COUNT  = BASE + 16'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        hit;
  logic        irq;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  logic [7:0]  sb [$];

  uart_rx_port #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (2)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .rx       (rx),
    .address  (address),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .hit      (hit),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [15:0] addr, output logic [7:0] d);
    @(negedge clk);
    address  = addr;
    write_en = 1'b0;
    #1;
    d = data_out;
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [7:0] d);
    @(negedge clk);
    address  = addr;
    data_in  = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic chk_reg(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    read_reg(addr, d);
    check(tag, d, exp);
  endtask

  // Read the head byte against the scoreboard, then pop it
  task automatic pop_check(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    read_reg(A_DATA, d);
    check(tag, d, exp);
    write_reg(A_DATA, 8'h00);
  endtask

  // One 8N1 frame; bit edges fall on negedges, stop level/length selectable
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_clks);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_lvl;
    repeat (stop_clks) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expect_push);
    if (expect_push) sb.push_back(b);
    send_frame(b, 1'b1, CPB);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bytes4 [4];
    rst_n    = 1'b0;
    rx       = 1'b1;
    address  = A_STATUS;
    write_en = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_irq", {7'd0, irq}, 8'h00);
    check("reset_status", data_out, 8'h00);
    rst_n = 1'b1;
    chk_reg("reset_count", A_COUNT, 8'h00);

    // Single byte receive and pop
    send_byte(8'h41, 1'b1);
    chk_reg("t1_status", A_STATUS, 8'h01);
    chk_reg("t1_count", A_COUNT, 8'h01);
    check("t1_irq", {7'd0, irq}, 8'h01);
    pop_check("t1_rxdata");
    chk_reg("t1_status_after_pop", A_STATUS, 8'h00);
    check("t1_irq_after_pop", {7'd0, irq}, 8'h00);

    // Fill to full, then overrun
    bytes4 = '{8'h55, 8'hAA, 8'h00, 8'hFF};
    foreach (bytes4[i]) send_byte(bytes4[i], 1'b1);
    chk_reg("t2_status_full", A_STATUS, 8'h03);
    chk_reg("t2_count_full", A_COUNT, 8'h04);
    send_byte(8'h7E, 1'b0);
    chk_reg("t2_status_overrun", A_STATUS, 8'h07);
    chk_reg("t2_count_overrun", A_COUNT, 8'h04);
    @(negedge clk);
    address  = A_COUNT;
    write_en = 1'b1;
    #1;
    check("t2_write_zeroes_data_out", data_out, 8'h00);
    check("t2_hit_on_write", {7'd0, hit}, 8'h01);
    @(negedge clk);
    write_en = 1'b0;
    chk_reg("t2_count_write_ignored", A_COUNT, 8'h04);
    for (int i = 0; i < 4; i++) pop_check("t2_pop");
    chk_reg("t2_status_empty_ovr", A_STATUS, 8'h04);
    chk_reg("t2_rxdata_empty", A_DATA, 8'h00);
    write_reg(A_DATA, 8'h00);
    chk_reg("t2_count_pop_empty", A_COUNT, 8'h00);
    write_reg(A_STATUS, 8'h04);
    chk_reg("t2_status_cleared", A_STATUS, 8'h00);

    // Framing error with a long low stop, then recovery
    send_frame(8'h33, 1'b0, 40);
    repeat (200) @(negedge clk);
    chk_reg("t3_status_frame", A_STATUS, 8'h08);
    chk_reg("t3_count", A_COUNT, 8'h00);
    write_reg(A_STATUS, 8'h08);
    repeat (50) @(negedge clk);
    chk_reg("t3_single_frame_err", A_STATUS, 8'h00);
    send_byte(8'h34, 1'b1);
    chk_reg("t3_status_next", A_STATUS, 8'h01);
    pop_check("t3_rxdata_next");

    // Short low glitch while idle
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk_reg("t4_status", A_STATUS, 8'h00);
    chk_reg("t4_count", A_COUNT, 8'h00);

    // Full FIFO with a pop on the stop-sample edge of a fifth byte
    bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (bytes4[i]) send_byte(bytes4[i], 1'b1);
    chk_reg("t5_count_full", A_COUNT, 8'h04);
    void'(sb.pop_front());
    sb.push_back(8'h5C);
    fork
      send_frame(8'h5C, 1'b1, CPB);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        address  = A_DATA;
        write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
      end
    join
    chk_reg("t5_count_same", A_COUNT, 8'h04);
    chk_reg("t5_status_no_ovr", A_STATUS, 8'h03);
    for (int i = 0; i < 4; i++) pop_check("t5_pop");
    chk_reg("t5_status_empty", A_STATUS, 8'h00);

    // Reset in the middle of a frame with a byte already queued
    send_byte(8'h99, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_reg("t6_status", A_STATUS, 8'h00);
    chk_reg("t6_count", A_COUNT, 8'h00);
    check("t6_irq", {7'd0, irq}, 8'h00);
    send_byte(8'h5A, 1'b1);
    chk_reg("t6_count_next", A_COUNT, 8'h01);
    pop_check("t6_rxdata_next");

    // Addresses outside the register window
    send_byte(8'hE7, 1'b1);
    chk_reg("t7_below", 16'hf017, 8'h00);
    check("t7_below_hit", {7'd0, hit}, 8'h00);
    chk_reg("t7_above", 16'hf01b, 8'h00);
    check("t7_above_hit", {7'd0, hit}, 8'h00);
    chk_reg("t7_zero", 16'h0000, 8'h00);
    check("t7_zero_hit", {7'd0, hit}, 8'h00);
    chk_reg("t7_count_top", A_COUNT, 8'h01);
    check("t7_count_hit", {7'd0, hit}, 8'h01);
    pop_check("t7_rxdata");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_port
